pht_ctrl: RTL

PHT_CTRL -- requirements
Module: pht_ctrl

---
 rtl/pht_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/pht_ctrl.sv
// rtl/pht_ctrl.sv - PHT lookup/update arbiter with resolved-branch update queue.
// Define BPU_GSHARE_EN for gshare indexing (PC XOR GHR); default build is bimodal.

module pht_upd_queue #(
    parameter int IDX_W = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [IDX_W-1:0]         push_idx,
    input  logic                     push_taken,
    input  logic                     pop,
    output logic [IDX_W-1:0]         head_idx,
    output logic                     head_taken,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] mem_idx [DEPTH];
    logic [DEPTH-1:0] mem_taken;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset: pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_idx[wr_ptr]   <= push_idx;
            mem_taken[wr_ptr] <= push_taken;
        end
    end

    assign head_idx   = mem_idx[rd_ptr];
    assign head_taken = mem_taken[rd_ptr];
endmodule

module pht_ctrl #(
    parameter int ADDR_WIDTH  = 9,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                  in_Clk,
    input  logic                  in_Rst_N,
    input  logic                  in_fetch_valid,
    input  logic [63:0]           in_fetch_pc,
    output logic                  out_fetch_stall,
    output logic                  out_pred_valid,
    output logic                  out_pred_taken,
    output logic [ADDR_WIDTH-1:0] out_pred_idx,
    output logic [ADDR_WIDTH-1:0] out_pred_ghr,
    input  logic                  in_upd_valid,
    output logic                  out_upd_ready,
    input  logic [ADDR_WIDTH-1:0] in_upd_idx,
    input  logic                  in_upd_taken,
    input  logic                  in_upd_mispredict,
    input  logic [ADDR_WIDTH-1:0] in_upd_ghr,
    output logic [ADDR_WIDTH-1:0] out_pht_addr,
    output logic                  out_pht_we,
    output logic                  out_pht_data,
    input  logic                  in_pht_pred
);
    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(QUEUE_DEPTH);
    localparam logic [CNT_W-1:0] GRANT_LIMIT = CNT_W'(QUEUE_DEPTH - 1);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   ghr;
    logic [CNT_W-1:0]        q_count;
    logic [ADDR_WIDTH-1:0]   head_idx;
    logic                    head_taken;
    logic [ADDR_WIDTH-1:0]   fetch_idx;
    logic                    grant;
    logic                    pop;
    logic                    push;
    logic                    recover;
    logic                    unused_bits;

`ifdef BPU_GSHARE_EN
    assign fetch_idx = in_fetch_pc[ADDR_WIDTH+1:2] ^ ghr;
`else
    assign fetch_idx = in_fetch_pc[ADDR_WIDTH+1:2];
`endif

    assign unused_bits = ^{in_fetch_pc[63:ADDR_WIDTH+2], in_fetch_pc[1:0],
                           in_upd_ghr[ADDR_WIDTH-1]};

    // One PHT access per cycle: a lookup wins unless the queue is nearly full.
    always_comb begin
        grant = 1'b0;
        pop   = 1'b0;
        if (in_Rst_N) begin
            if (state == RUN) begin
                grant = in_fetch_valid && (q_count < GRANT_LIMIT);
                pop   = !grant && (q_count != '0);
            end else begin
                pop   = (q_count != '0);
            end
        end
    end

    assign out_upd_ready = in_Rst_N && ((q_count != FULL_CNT) || pop);
    assign push          = in_upd_valid && out_upd_ready;
    assign recover       = push && in_upd_mispredict;

    assign out_fetch_stall = in_Rst_N && in_fetch_valid && !grant;
    assign out_pred_valid  = grant;
    assign out_pred_taken  = grant && in_pht_pred;
    assign out_pred_idx    = grant ? fetch_idx : '0;
    assign out_pred_ghr    = grant ? ghr : '0;

    assign out_pht_we   = pop;
    assign out_pht_data = pop && head_taken;
    assign out_pht_addr = grant ? fetch_idx : (pop ? head_idx : '0);

    pht_upd_queue #(
        .IDX_W (ADDR_WIDTH),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (in_Clk),
        .resetn     (in_Rst_N),
        .push       (push),
        .push_idx   (in_upd_idx),
        .push_taken (in_upd_taken),
        .pop        (pop),
        .head_idx   (head_idx),
        .head_taken (head_taken),
        .count      (q_count)
    );

    // Mispredict recovery takes precedence over a same-cycle speculative shift.
    always_ff @(posedge in_Clk) begin
        if (!in_Rst_N) begin
            state <= RUN;
            ghr   <= '0;
        end else begin
            if (recover) begin
                ghr <= {in_upd_ghr[ADDR_WIDTH-2:0], in_upd_taken};
            end else if (grant) begin
                ghr <= {ghr[ADDR_WIDTH-2:0], in_pht_pred};
            end
            case (state)
                RUN: begin
                    if (recover) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!recover && (q_count == '0) && !push) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule
